// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding unit: forward selects and the
// multi-cycle tracker state.
package hazard_pkg;

    typedef enum logic {IDLE, BUSY} mc_state_e;

    // EX-stage operand select
    localparam logic [1:0] FWD_E_RF  = 2'b00;
    localparam logic [1:0] FWD_E_WB  = 2'b01;
    localparam logic [1:0] FWD_E_MEM = 2'b10;

    // ID-stage branch comparator select
    localparam logic [1:0] FWD_D_RF  = 2'b00;
    localparam logic [1:0] FWD_D_MEM = 2'b01;
    localparam logic [1:0] FWD_D_EX  = 2'b10;

endpackage

// File: rtl/mc_busy_tracker.sv
// Tracks a multi-cycle execute op and raises mc_hold for MC_LAT-1 cycles,
// starting with the cycle mc_start_e is seen.
module mc_busy_tracker
    import hazard_pkg::*;
#(
    parameter int unsigned MC_LAT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic mc_start_e,
    output logic mc_hold,
    output logic mc_busy
);

    localparam int unsigned CNT_AW = (MC_LAT > 2) ? $clog2(MC_LAT - 1) : 1;
    localparam bit MULTI = (MC_LAT > 1);
    localparam logic [CNT_AW-1:0] LOAD = MULTI ? CNT_AW'(MC_LAT - 2) : '0;

    mc_state_e         state_q, state_d;
    logic [CNT_AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The last BUSY cycle (cnt==0) already releases the pipeline, so the
    // hold lasts MC_LAT-1 cycles and mc_busy trails it by one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mc_hold = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mc_start_e && MULTI) begin
                    state_d = BUSY;
                    cnt_d   = LOAD;
                    mc_hold = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    mc_hold = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mc_busy = (state_q == BUSY);

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding unit for the 5-stage pipeline: EX/ID forwarding selects,
// load-use and branch stalls, multi-cycle EX hold and a stall-cycle counter.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned MC_LAT   = 4,
    parameter int unsigned ZERO_FWD = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              branch_d,
    input  logic              pc_src_d,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rt_e,
    input  logic [REG_AW-1:0] write_reg_e,
    input  logic              reg_write_e,
    input  logic              mem_to_reg_e,
    input  logic [REG_AW-1:0] write_reg_m,
    input  logic              reg_write_m,
    input  logic              mem_to_reg_m,
    input  logic [REG_AW-1:0] write_reg_w,
    input  logic              reg_write_w,
    input  logic              mc_start_e,
    output logic [1:0]        forward_ae,
    output logic [1:0]        forward_be,
    output logic [1:0]        forward_ad,
    output logic [1:0]        forward_bd,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic              mc_busy,
    output logic [CNT_W-1:0]  stall_cycles
);

    logic             mc_hold;
    logic [CNT_W-1:0] cnt_q;

    mc_busy_tracker #(
        .MC_LAT (MC_LAT)
    ) u_tracker (
        .clk        (clk),
        .reset_n    (reset_n),
        .mc_start_e (mc_start_e),
        .mc_hold    (mc_hold),
        .mc_busy    (mc_busy)
    );

    // Register 0 is hard-wired to zero unless ZERO_FWD allows matching it.
    function automatic logic match(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
        return (a == b) && ((ZERO_FWD != 0) || (a != '0));
    endfunction

    function automatic logic [1:0] fwd_e(input logic [REG_AW-1:0] src);
        if (reg_write_m && match(src, write_reg_m)) return FWD_E_MEM;
        if (reg_write_w && match(src, write_reg_w)) return FWD_E_WB;
        return FWD_E_RF;
    endfunction

    function automatic logic [1:0] fwd_d(input logic [REG_AW-1:0] src);
        if (reg_write_m && !mem_to_reg_m && match(src, write_reg_m)) return FWD_D_MEM;
        if (branch_d && reg_write_e && !mem_to_reg_e && match(src, write_reg_e)) return FWD_D_EX;
        return FWD_D_RF;
    endfunction

    logic lwstall, brstall_e, brstall_m, hz;

    always_comb begin
        lwstall   = mem_to_reg_e && (match(rs_d, rt_e) || match(rt_d, rt_e));
        brstall_e = branch_d && reg_write_e && mem_to_reg_e &&
                    (match(write_reg_e, rs_d) || match(write_reg_e, rt_d));
        brstall_m = branch_d && mem_to_reg_m &&
                    (match(write_reg_m, rs_d) || match(write_reg_m, rt_d));
        hz        = lwstall | brstall_e | brstall_m;

        forward_ae = '0;
        forward_be = '0;
        forward_ad = '0;
        forward_bd = '0;
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        stall_e    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        flush_m    = 1'b0;
        if (reset_n) begin
            forward_ae = fwd_e(rs_e);
            forward_be = fwd_e(rt_e);
            forward_ad = fwd_d(rs_d);
            forward_bd = fwd_d(rt_d);
            stall_f    = hz | mc_hold;
            stall_d    = hz | mc_hold;
            stall_e    = mc_hold;
            flush_e    = hz & !mc_hold;
            flush_m    = mc_hold;
            flush_d    = pc_src_d & !(hz | mc_hold);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (stall_f && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc with default parameters
// (REG_AW=5, MC_LAT=4, ZERO_FWD=0, CNT_W=16).
module tb_hazard_unit_mc;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        branch_d, pc_src_d;
    logic [4:0]  rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
    logic        reg_write_e, mem_to_reg_e, reg_write_m, mem_to_reg_m, reg_write_w;
    logic        mc_start_e;
    logic [1:0]  forward_ae, forward_be, forward_ad, forward_bd;
    logic        stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_busy;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_unit_mc dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .branch_d     (branch_d),
        .pc_src_d     (pc_src_d),
        .rs_d         (rs_d),
        .rt_d         (rt_d),
        .rs_e         (rs_e),
        .rt_e         (rt_e),
        .write_reg_e  (write_reg_e),
        .reg_write_e  (reg_write_e),
        .mem_to_reg_e (mem_to_reg_e),
        .write_reg_m  (write_reg_m),
        .reg_write_m  (reg_write_m),
        .mem_to_reg_m (mem_to_reg_m),
        .write_reg_w  (write_reg_w),
        .reg_write_w  (reg_write_w),
        .mc_start_e   (mc_start_e),
        .forward_ae   (forward_ae),
        .forward_be   (forward_be),
        .forward_ad   (forward_ad),
        .forward_bd   (forward_bd),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .stall_e      (stall_e),
        .flush_d      (flush_d),
        .flush_e      (flush_e),
        .flush_m      (flush_m),
        .mc_busy      (mc_busy),
        .stall_cycles (stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        branch_d = 0; pc_src_d = 0; rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
        write_reg_e = 0; reg_write_e = 0; mem_to_reg_e = 0;
        write_reg_m = 0; reg_write_m = 0; mem_to_reg_m = 0;
        write_reg_w = 0; reg_write_w = 0; mc_start_e = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear();
        reset_n = 0;
        rs_e = 3; write_reg_m = 3; reg_write_m = 1; mem_to_reg_e = 1; rt_e = 5; rs_d = 5;
        #1;
        chk("rst_fwd_ae", forward_ae, 2'b00);
        chk("rst_stall_f", stall_f, 0);
        chk("rst_flush_e", flush_e, 0);
        tick();
        tick();
        chk("rst_cnt", stall_cycles, 0);
        chk("rst_busy", mc_busy, 0);
        clear();
        reset_n = 1;
        #1;
        chk("idle_stall_f", stall_f, 0);

        // EX forwarding: MEM beats WB, then WB alone
        rs_e = 3; write_reg_m = 3; reg_write_m = 1; write_reg_w = 3; reg_write_w = 1; #1;
        chk("fwd_ae_mem", forward_ae, 2'b10);
        reg_write_m = 0; #1;
        chk("fwd_ae_wb", forward_ae, 2'b01);
        rt_e = 3; #1;
        chk("fwd_be_wb", forward_be, 2'b01);

        // Register 0 never matches
        clear();
        rs_e = 0; write_reg_m = 0; reg_write_m = 1; #1;
        chk("fwd_ae_r0", forward_ae, 2'b00);
        mem_to_reg_e = 1; rt_e = 0; rs_d = 0; #1;
        chk("lw_r0_stall", stall_f, 0);
        tick();

        // Load-use stall, taken branch suppressed by the stall
        clear();
        mem_to_reg_e = 1; rt_e = 5; rs_d = 5; pc_src_d = 1; #1;
        chk("lw_stall_f", stall_f, 1);
        chk("lw_stall_d", stall_d, 1);
        chk("lw_flush_e", flush_e, 1);
        chk("lw_stall_e", stall_e, 0);
        chk("lw_flush_d", flush_d, 0);
        tick();
        mem_to_reg_e = 0; rt_e = 0;
        write_reg_m = 5; reg_write_m = 1; mem_to_reg_m = 1; #1;
        chk("lw_mem_stall", stall_f, 0);
        chk("lw_mem_flush_e", flush_e, 0);
        chk("lw_mem_fwd_ad", forward_ad, 2'b00);
        chk("flush_d_taken", flush_d, 1);
        chk("cnt_one", stall_cycles, 1);
        clear();
        tick();

        // Branch comparator forwarding and branch stalls
        branch_d = 1; rs_d = 7; write_reg_e = 7; reg_write_e = 1; #1;
        chk("br_fwd_ad_ex", forward_ad, 2'b10);
        chk("br_no_stall", stall_f, 0);
        mem_to_reg_e = 1; #1;
        chk("br_stall_e", stall_d, 1);
        chk("br_stall_e_fwd", forward_ad, 2'b00);
        write_reg_e = 0; reg_write_e = 0; mem_to_reg_e = 0;
        write_reg_m = 7; reg_write_m = 1; mem_to_reg_m = 1; #1;
        chk("br_stall_m", stall_f, 1);
        mem_to_reg_m = 0; #1;
        chk("br_fwd_ad_mem", forward_ad, 2'b01);
        chk("br_alu_m_nostall", stall_f, 0);
        write_reg_m = 0; reg_write_m = 0; write_reg_w = 7; reg_write_w = 1; #1;
        chk("br_wb_fwd_ad", forward_ad, 2'b00);
        chk("br_wb_stall", stall_f, 0);
        rt_d = 7; write_reg_m = 7; reg_write_m = 1; #1;
        chk("br_fwd_bd_mem", forward_bd, 2'b01);
        clear();
        tick();

        // Multi-cycle op, MC_LAT=4: hold cycles 0-2, busy cycles 1-3
        mc_start_e = 1; #1;
        chk("mc0_stall_f", stall_f, 1);
        chk("mc0_stall_e", stall_e, 1);
        chk("mc0_flush_m", flush_m, 1);
        chk("mc0_busy", mc_busy, 0);
        tick();                                  // cnt 2
        mc_start_e = 0;
        mem_to_reg_e = 1; rt_e = 5; rs_d = 5; #1;
        chk("mc1_stall_d", stall_d, 1);
        chk("mc1_flush_e", flush_e, 0);
        chk("mc1_busy", mc_busy, 1);
        clear();
        tick();                                  // cnt 3
        #1;
        chk("mc2_stall_e", stall_e, 1);
        chk("mc2_busy", mc_busy, 1);
        tick();                                  // cnt 4
        #1;
        chk("mc3_stall_f", stall_f, 0);
        chk("mc3_stall_e", stall_e, 0);
        chk("mc3_flush_m", flush_m, 0);
        chk("mc3_busy", mc_busy, 1);
        tick();
        #1;
        chk("mc4_busy", mc_busy, 0);
        chk("mc_cnt", stall_cycles, 4);

        // Reset in the middle of an op aborts it
        mc_start_e = 1; #1;
        chk("mcr0_stall_e", stall_e, 1);
        tick();
        mc_start_e = 0; reset_n = 0; #1;
        chk("mcr1_stall_e", stall_e, 0);
        chk("mcr1_flush_m", flush_m, 0);
        chk("mcr1_stall_f", stall_f, 0);
        tick();
        reset_n = 1; #1;
        chk("mcr2_busy", mc_busy, 0);
        chk("mcr2_stall_e", stall_e, 0);
        chk("mcr2_cnt", stall_cycles, 0);

        // Constant load-use stall until the counter saturates
        mem_to_reg_e = 1; rt_e = 9; rt_d = 9;
        for (int i = 0; i < 3; i++) tick();
        chk("sat_cnt3", stall_cycles, 3);
        for (int i = 0; i < 65540; i++) tick();
        chk("sat_cnt_max", stall_cycles, 16'hFFFF);
        tick();
        chk("sat_cnt_hold", stall_cycles, 16'hFFFF);
        clear();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
